// File: rtl/dcp_atmos_light_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcp_atmos_light_ctrl_if
//  Description : Bundle of the frame-control signals of the atmospheric-light
//                controller. The master side is the video source / host: it
//                drives enable, vsync and the dark-channel pixel stream. The
//                slave side is the controller, which returns the
//                atmospheric-light register and its status.
//  Signals     : i_enable      controller enable
//                i_vsync       active-high vertical blanking
//                i_data_valid  dark-channel pixel valid
//                i_dark[7:0]   dark-channel pixel value
//                o_dark_max    registered atmospheric light
//                o_update      one-cycle load pulse
//                o_frame_cnt   completed-frame counter
//                o_timeout     vsync watchdog expired
//  Revision    : 1.0 - initial release
// ============================================================================
interface dcp_atmos_light_ctrl_if;
   logic        i_enable;
   logic        i_vsync;
   logic        i_data_valid;
   logic [7:0]  i_dark;
   logic [7:0]  o_dark_max;
   logic        o_update;
   logic [15:0] o_frame_cnt;
   logic        o_timeout;

   modport master (
      output i_enable, i_vsync, i_data_valid, i_dark,
      input  o_dark_max, o_update, o_frame_cnt, o_timeout
   );

   modport slave (
      input  i_enable, i_vsync, i_data_valid, i_dark,
      output o_dark_max, o_update, o_frame_cnt, o_timeout
   );
endinterface
`default_nettype wire

// File: rtl/dcp_atmos_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcp_atmos_light_ctrl
//  Description : Frame-level atmospheric-light controller for a dark-channel
//                prior defogging datapath. Tracks the maximum dark-channel
//                value of each frame, qualifies it (minimum pixel count,
//                MIN_A floor, optional IIR smoothing) and loads it into
//                o_dark_max only at frame boundaries. A vsync watchdog falls
//                back to DEFAULT_A when vsync disappears.
//  Ports       : pixelclk   pixel clock
//                reset_n    asynchronous active-low reset
//                bus        dcp_atmos_light_ctrl_if.slave (enable, vsync,
//                           pixel stream in; dark_max, update, frame count,
//                           timeout out)
//  Options     : DCP_AL_SMOOTH_EN - when defined, each accepted frame result
//                is blended into o_dark_max with a 1/2^SMOOTH_K IIR.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcp_atmos_light_ctrl #(
   parameter logic [7:0] DEFAULT_A = 8'd220,
   parameter logic [7:0] MIN_A     = 8'd100,
   parameter int         MIN_PIX   = 16,
   parameter int         PIX_W     = 22,
   parameter int         TIMEOUT_W = 24,
   parameter int         SMOOTH_K  = 2
) (
   input  wire                      pixelclk,
   input  wire                      reset_n,
   dcp_atmos_light_ctrl_if.slave    bus
);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_ACCUM  = 2'd1;
   localparam logic [1:0] c_UPDATE = 2'd2;

   localparam logic [PIX_W-1:0]     c_PIX_MAX = {PIX_W{1'b1}};
   localparam logic [PIX_W-1:0]     c_MIN_PIX = PIX_W'(MIN_PIX);
   localparam logic [TIMEOUT_W-1:0] c_WD_MAX  = {TIMEOUT_W{1'b1}};
   localparam logic [TIMEOUT_W-1:0] c_WD_PRE  = c_WD_MAX - 1'b1;

   logic [1:0]           r_state;
   logic                 r_vsync_d;
   logic [7:0]           r_acc_max;
   logic [PIX_W-1:0]     r_acc_pix;
   logic [7:0]           r_frm_max;
   logic [PIX_W-1:0]     r_frm_pix;
   logic [TIMEOUT_W-1:0] r_wdog;
   logic                 r_ld_pend;
   logic [7:0]           r_ld_val;
   logic [7:0]           r_dark_max;
   logic                 r_update;
   logic [15:0]          r_frame_cnt;
   logic                 r_timeout;

   logic                 w_rise;
   logic                 w_qual;
   logic                 w_wd_fire;
   logic [7:0]           w_cand;
   logic [7:0]           w_filt;

   assign w_rise = bus.i_vsync & ~r_vsync_d;
   // Pixels seen during blanking or while the controller is idle/disabled
   // never reach the accumulators.
   assign w_qual = bus.i_data_valid & ~bus.i_vsync & (r_state != c_IDLE) & bus.i_enable;
   // Fires exactly once, on the edge where the watchdog reaches all-ones;
   // a coincident rise wins because it restarts the watchdog.
   assign w_wd_fire = ~w_rise & (r_wdog == c_WD_PRE);
   assign w_cand = (r_frm_max < MIN_A) ? MIN_A : r_frm_max;

`ifdef DCP_AL_SMOOTH_EN
   logic [8+SMOOTH_K:0] w_mix;
   // Largest value is 255*2^K, which fits below 2^(8+K), so the shifted
   // result always fits in 8 bits.
   assign w_mix  = (9+SMOOTH_K)'(r_dark_max) * (9+SMOOTH_K)'((1 << SMOOTH_K) - 1)
                 + (9+SMOOTH_K)'(w_cand);
   assign w_filt = w_mix[SMOOTH_K +: 8];
`else
   assign w_filt = w_cand;
`endif

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         r_vsync_d <= 1'b0;
         r_wdog    <= '0;
      end else begin
         r_vsync_d <= bus.i_vsync;
         if (w_rise)
            r_wdog <= '0;
         else if (r_wdog != c_WD_MAX)
            r_wdog <= r_wdog + 1'b1;
      end
   end

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= c_IDLE;
         r_acc_max   <= '0;
         r_acc_pix   <= '0;
         r_frm_max   <= '0;
         r_frm_pix   <= '0;
         r_ld_pend   <= 1'b0;
         r_ld_val    <= '0;
         r_dark_max  <= DEFAULT_A;
         r_update    <= 1'b0;
         r_frame_cnt <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_update <= 1'b0;
         if (w_wd_fire) begin
            r_timeout  <= 1'b1;
            r_dark_max <= DEFAULT_A;
            r_state    <= c_IDLE;
            r_acc_max  <= '0;
            r_acc_pix  <= '0;
            r_ld_pend  <= 1'b0;
         end else if (!bus.i_enable) begin
            r_state   <= c_IDLE;
            r_acc_max <= '0;
            r_acc_pix <= '0;
            r_ld_pend <= 1'b0;
         end else begin
            if (w_rise)
               r_timeout <= 1'b0;

            if (w_qual) begin
               if (bus.i_dark > r_acc_max)
                  r_acc_max <= bus.i_dark;
               if (r_acc_pix != c_PIX_MAX)
                  r_acc_pix <= r_acc_pix + 1'b1;
            end

            // Second pipeline stage: the result computed in UPDATE is
            // committed one cycle later, giving a two-cycle rise-to-output
            // latency identical in both builds.
            if (r_ld_pend) begin
               r_dark_max <= r_ld_val;
               r_update   <= 1'b1;
               r_ld_pend  <= 1'b0;
            end

            case (r_state)
               c_IDLE: begin
                  if (w_rise) begin
                     r_state   <= c_ACCUM;
                     r_acc_max <= '0;
                     r_acc_pix <= '0;
                  end
               end
               c_ACCUM: begin
                  if (w_rise) begin
                     r_frm_max <= r_acc_max;
                     r_frm_pix <= r_acc_pix;
                     r_acc_max <= '0;
                     r_acc_pix <= '0;
                     r_state   <= c_UPDATE;
                  end
               end
               c_UPDATE: begin
                  r_state     <= c_ACCUM;
                  r_frame_cnt <= r_frame_cnt + 1'b1;
                  if (r_frm_pix >= c_MIN_PIX) begin
                     r_ld_val  <= w_filt;
                     r_ld_pend <= 1'b1;
                  end
               end
               default: r_state <= c_IDLE;
            endcase
         end
      end
   end

   assign bus.o_dark_max  = r_dark_max;
   assign bus.o_update    = r_update;
   assign bus.o_frame_cnt = r_frame_cnt;
   assign bus.o_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_dcp_atmos_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcp_atmos_light_ctrl
//  Description : Directed self-checking bench for dcp_atmos_light_ctrl.
//                Watchdog width is reduced to 8 bits so a timeout can be
//                reached quickly. Expected atmospheric-light values are hand
//                computed for both the plain and the DCP_AL_SMOOTH_EN build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcp_atmos_light_ctrl;

`ifdef DCP_AL_SMOOTH_EN
   localparam logic [7:0] c_EA = 8'd215;  // (220*3+200)>>2
   localparam logic [7:0] c_EB = 8'd186;  // (215*3+100)>>2
   localparam logic [7:0] c_EC = 8'd164;  // (186*3+100)>>2
   localparam logic [7:0] c_EE = 8'd168;  // (164*3+180)>>2
   localparam logic [7:0] c_EF = 8'd190;  // (220*3+100)>>2
   localparam logic [7:0] c_EG = 8'd167;  // (190*3+100)>>2
   localparam logic [7:0] c_EH = 8'd162;  // (167*3+150)>>2
`else
   localparam logic [7:0] c_EA = 8'd200;
   localparam logic [7:0] c_EB = 8'd100;
   localparam logic [7:0] c_EC = 8'd100;
   localparam logic [7:0] c_EE = 8'd180;
   localparam logic [7:0] c_EF = 8'd100;
   localparam logic [7:0] c_EG = 8'd100;
   localparam logic [7:0] c_EH = 8'd150;
`endif

   logic pixelclk = 1'b0;
   logic reset_n  = 1'b0;
   int   n_tests  = 0;
   int   n_fail   = 0;

   dcp_atmos_light_ctrl_if bus ();

   dcp_atmos_light_ctrl #(
      .TIMEOUT_W (8)
   ) u_dut (
      .pixelclk (pixelclk),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   always #5 pixelclk = ~pixelclk;

   task automatic tick();
      @(posedge pixelclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // n qualified pixels, one of them at 'peak', others at peak/2; every
   // eighth cycle carries an invalid 255 that must be ignored.
   task automatic pixels(input int n, input logic [7:0] peak);
      for (int i = 0; i < n; i++) begin
         if ((i % 8) == 7) begin
            bus.i_data_valid = 1'b0;
            bus.i_dark       = 8'd255;
            tick();
         end
         bus.i_data_valid = 1'b1;
         bus.i_dark       = (i == n / 2) ? peak : (peak >> 1);
         tick();
      end
      bus.i_data_valid = 1'b0;
      bus.i_dark       = 8'd0;
   endtask

   // Raise vsync (with bogus valid pixels of 250 during blanking) and check
   // outputs one, two and three edges after the rise is sampled.
   task automatic frame_end(input string tag, input logic upd, input logic [7:0] dm,
                            input logic [15:0] cnt);
      bus.i_vsync      = 1'b1;
      bus.i_data_valid = 1'b1;
      bus.i_dark       = 8'd250;
      tick();
      tick();
      chk({tag, "_upd_e1"}, bus.o_update, 1'b0);
      chk({tag, "_to_e1"},  bus.o_timeout, 1'b0);
      tick();
      chk({tag, "_upd_e2"}, bus.o_update, upd);
      chk({tag, "_dm_e2"},  bus.o_dark_max, dm);
      chk({tag, "_cnt_e2"}, bus.o_frame_cnt, cnt);
      tick();
      chk({tag, "_upd_e3"}, bus.o_update, 1'b0);
      bus.i_vsync      = 1'b0;
      bus.i_data_valid = 1'b0;
      bus.i_dark       = 8'd0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL tb_time_limit observed=expired expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      bus.i_enable     = 1'b1;
      bus.i_vsync      = 1'b0;
      bus.i_data_valid = 1'b0;
      bus.i_dark       = 8'd0;
      repeat (3) tick();
      chk("rst_dm",  bus.o_dark_max, 8'd220);
      chk("rst_upd", bus.o_update, 1'b0);
      chk("rst_cnt", bus.o_frame_cnt, 16'd0);
      chk("rst_to",  bus.o_timeout, 1'b0);
      reset_n = 1'b1;
      repeat (2) tick();

      // First rise only leaves IDLE; the partial frame is discarded.
      pixels(20, 8'd240);
      frame_end("first", 1'b0, 8'd220, 16'd0);

      pixels(100, 8'd200);
      frame_end("frmA", 1'b1, c_EA, 16'd1);

      // Max 50 clamps to MIN_A; 250s during blanking must be ignored.
      pixels(100, 8'd50);
      frame_end("frmB", 1'b1, c_EB, 16'd2);
      pixels(100, 8'd50);
      frame_end("frmC", 1'b1, c_EC, 16'd3);

      // Too few pixels: held value, no pulse, frame still counted.
      pixels(10, 8'd255);
      frame_end("frmD", 1'b0, c_EC, 16'd4);

      // Exactly MIN_PIX pixels is accepted.
      pixels(16, 8'd180);
      frame_end("frmE", 1'b1, c_EE, 16'd5);

      // Watchdog: rise sampled at edge E0, frame_end consumed E0..E4.
      repeat (250) tick();
      chk("wd_pre_to", bus.o_timeout, 1'b0);
      tick();
      chk("wd_to",  bus.o_timeout, 1'b1);
      chk("wd_dm",  bus.o_dark_max, 8'd220);
      chk("wd_upd", bus.o_update, 1'b0);
      chk("wd_cnt", bus.o_frame_cnt, 16'd5);

      // Controller is IDLE: next rise clears timeout without an update.
      pixels(30, 8'd240);
      frame_end("toclr", 1'b0, 8'd220, 16'd5);

      pixels(100, 8'd60);
      frame_end("frmF", 1'b1, c_EF, 16'd6);
      pixels(100, 8'd60);
      frame_end("frmG", 1'b1, c_EG, 16'd7);

      // Enable dropped mid-frame: the frame produces nothing.
      pixels(50, 8'd240);
      bus.i_enable = 1'b0;
      repeat (2) tick();
      bus.i_enable = 1'b1;
      pixels(50, 8'd240);
      frame_end("endrop", 1'b0, c_EG, 16'd7);

      pixels(40, 8'd150);
      frame_end("frmH", 1'b1, c_EH, 16'd8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dcp_atmos_light_ctrl.md
Name: dcp_atmos_light_ctrl

Overview:
Frame-level controller that sequences the dark-channel-prior defogging datapath. It tracks the maximum dark-channel value over each active frame and qualifies it (minimum pixel count, floor clamp, optional temporal smoothing). At every frame boundary it loads the result into the atmospheric-light register that drives the defogging stage's i_dark_max. Between boundaries the register is held constant, so the datapath never sees a mid-frame change. A watchdog reverts to a safe default when vsync is lost.

Parameters:
DEFAULT_A, 8'd220, atmospheric light loaded at reset, on timeout, and while no valid frame has completed
MIN_A, 8'd100, floor clamp applied to each per-frame candidate
MIN_PIX, 16, minimum qualified pixels a frame needs before its result is accepted
PIX_W, 22, width of the per-frame pixel counter (saturating)
TIMEOUT_W, 24, width of the vsync watchdog counter; timeout fires at 2^TIMEOUT_W-1 cycles
SMOOTH_K, 2, IIR shift for smoothing (only used with DCP_AL_SMOOTH_EN)

Ports:
pixelclk  in  1  pixel clock, single clock domain
reset_n  in  1  asynchronous active-low reset
i_enable  in  1  controller enable; low forces IDLE and holds o_dark_max
i_vsync  in  1  active-high vertical blanking; rising edge marks frame end/start
i_data_valid  in  1  dark-channel pixel valid
i_dark  in  8  dark-channel pixel value
o_dark_max  out  8  registered atmospheric light to the defogging stage
o_update  out  1  one-cycle pulse when o_dark_max is loaded from a frame result
o_frame_cnt  out  16  count of completed frames, wraps at 16'hFFFF->0
o_timeout  out  1  high while the watchdog has expired

Behaviour:
- Reset (async, reset_n low): o_dark_max=DEFAULT_A, o_update=0, o_frame_cnt=0, o_timeout=0, state=IDLE, accumulators=0, vsync_d=0, watchdog=0.
- rise = i_vsync & ~vsync_d; vsync_d is registered i_vsync.
- Qualified pixel = i_data_valid & ~i_vsync & state!=IDLE & i_enable. Valid asserted during vsync high is ignored.
- Accumulators: acc_max = max(acc_max, i_dark); acc_pix increments and saturates at all-ones. Both are active in ACCUM and UPDATE.
- At a rise cycle (ACCUM): snapshot acc_max->frm_max and acc_pix->frm_pix. Clear the accumulators; a qualified pixel in the same cycle cannot occur because vsync is high. Next state is UPDATE.
- FSM:
  - IDLE: on rise -> ACCUM, with accumulators cleared; the partial frame is discarded.
  - ACCUM: on rise -> UPDATE.
  - UPDATE: lasts one cycle, then -> ACCUM.
- UPDATE work:
  - If frm_pix >= MIN_PIX: cand = max(frm_max, MIN_A). o_dark_max <= filtered cand. o_update <= 1 for one cycle.
  - Else: o_dark_max is held and o_update stays 0.
  - o_frame_cnt increments in both cases.
- Latency: o_dark_max and o_update become visible 2 cycles after the rise cycle's sampling edge.
- i_enable low: next state is IDLE, the accumulators clear, and o_dark_max, o_frame_cnt and o_timeout hold; o_update=0. The watchdog keeps counting. On re-enable the controller waits for the next rise.
- Watchdog: clears on every rise and increments otherwise, saturating.
  - On reaching all-ones: o_timeout<=1, o_dark_max<=DEFAULT_A, state<=IDLE, no o_update.
  - o_timeout clears at the next rise.
- Arithmetic is unsigned. Smoothing uses an intermediate of 8+SMOOTH_K+1 bits; the result is truncated to 8 bits and never exceeds 255.

Optional Feature:
DCP_AL_SMOOTH_EN:
- Defined: o_dark_max <= (o_dark_max*((1<<SMOOTH_K)-1) + cand) >> SMOOTH_K, a temporal IIR that suppresses flicker.
- Undefined: o_dark_max <= cand directly, and SMOOTH_K is unused.
- All other behaviour and the latency are identical in both builds.

Test Plan:
1. Reset -> o_dark_max=220, o_frame_cnt=0, o_update=0, o_timeout=0. The first rise causes no update (IDLE->ACCUM).
2. Smoothing off; frame of 100 valid pixels with max i_dark=200 -> 2 cycles after the rise: o_dark_max=200, o_update single pulse, o_frame_cnt=1.
3. Frame max 50 -> o_dark_max=100 (MIN_A clamp). Valid pixels with i_dark=250 driven while vsync is high -> ignored; result stays 100.
4. Frame with 10 valid pixels (<MIN_PIX) -> o_dark_max unchanged, o_update stays 0, o_frame_cnt increments.
5. DCP_AL_SMOOTH_EN, SMOOTH_K=2, o_dark_max=220, frame cand=100 -> o_dark_max=(660+100)>>2=190. Next frame cand=100 -> (570+100)>>2=167.
6. TIMEOUT_W=8, o_dark_max=200, no vsync for 255 cycles -> o_timeout=1, o_dark_max=220, state=IDLE. Next rise clears o_timeout with no update. Deasserting i_enable mid-frame -> that frame yields no update.
